sparse_syncram: RTL and testbench
=================================

Name: sparse_syncram

Overview:
- Parametrised associative (sparse) synchronous RAM. Stores up to DEPTH address/data pairs for arbitrary AW-bit addresses and looks them up by full-address match.
- Next-generation data/instruction memory model for the single-cycle processor.
- Adds over the previous generation: reset, valid tracking, byte-enabled writes, entry invalidation, full/miss reporting, and a registered read with fixed latency.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits; must be a multiple of 8
DEPTH, 64, number of address/data entries (≥2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
cs  in  1  chip select; we, oe and clr are ignored when low
we  in  1  write request
oe  in  1  read request
clr  in  1  invalidate the entry matching addr
be  in  DW/8  byte enables for writes; bit i covers din[8i+7:8i]
addr  in  AW  lookup address
din  in  DW  write data
dout  out  DW  registered read data
rd_valid  out  1  one-cycle pulse: dout updated by a read
rd_miss  out  1  with rd_valid: address was not present
wr_drop  out  1  one-cycle pulse: write miss dropped because memory full
full  out  1  all DEPTH entries valid
count  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset (async assert, sync release): all valid bits 0; dout=0; rd_valid, rd_miss and wr_drop = 0; count=0; full=0. Entry tag/data contents are don't-care.
- Lookup: combinational compare of addr against all valid tags. Uniqueness is guaranteed by construction, so at most one match.
- Operation priority within a cycle (cs=1): clr overrides we. The read is evaluated on pre-edge state, i.e. read-before-write.
- Write, hit (cs&we&~clr):
  - Matching entry's bytes with be[i]=1 take din; others keep their value.
  - be=0 is a legal no-op.
- Write, miss, not full:
  - Allocate the lowest-index invalid entry.
  - Set tag=addr and valid=1.
  - Bytes with be=0 are written as 0.
  - count increments.
- Write, miss, full:
  - No state change.
  - wr_drop=1 for the next cycle only.
- Clear (cs&clr):
  - On a hit, the matching valid bit goes to 0 and count decrements.
  - On a miss, no effect and no flag.
  - The freed slot is reusable from the next cycle.
- Read (cs&oe): latency 1. On the following cycle rd_valid=1.
  - Hit: dout = stored data (pre-write value if the same address is written in the same cycle); rd_miss=0.
  - Miss: dout=0; rd_miss=1.
  - A read of an address being newly allocated in the same cycle is a miss.
  - A read of an address being cleared in the same cycle returns the old data as a hit.
- When no read occurs: rd_valid=0, rd_miss=0, and dout holds its last value.
- full == (count==DEPTH), registered alongside count.
- Simultaneous clr of one entry and we-miss of another while full: clr wins, the write is ignored, and wr_drop is not asserted.
- Back-to-back operations every cycle are supported; there are no stalls.
- Reset mid-operation: pending read responses are discarded and rd_valid=0 immediately.

Optional Feature:
- Macro SPARSE_SYNCRAM_STATS_EN.
- When defined, adds two outputs:
  - hit_cnt (16 bits): increments on each read hit.
  - miss_cnt (16 bits): increments on each read miss.
  - Both saturate at 16'hFFFF and reset to 0.
  - Both are updated in the same cycle rd_valid is asserted.
- When undefined, neither port nor counter logic exists and all other behaviour is identical.

Test Plan:
- Reset, then write addr=0x1000_0040 din=0xDEAD_BEEF be=4'hF, then read 0x1000_0040 -> next cycle rd_valid=1, rd_miss=0, dout=0xDEADBEEF; count=1.
- Read unwritten addr=0x0000_0004 -> rd_valid=1, rd_miss=1, dout=0; count unchanged.
- Partial write to the existing entry 0x1000_0040 with be=4'b0011, din=0x1234_5678, then read -> dout=0xDEAD5678.
- Fill DEPTH=4 with distinct addresses -> full=1, count=4. Fifth new-address write -> wr_drop one-cycle pulse; a read of that address misses. Clear entry 2 -> count=3, full=0. Rewrite the new address -> allocated to index 2, read hits.
- Same-cycle we+oe to 0x20 holding 0xAAAA_AAAA with din=0x5555_5555 -> dout=0xAAAAAAAA. The next read returns 0x55555555.
- Assert rst_n=0 asynchronously between clock edges after a read request -> rd_valid, dout and count drop to 0 immediately. After release, a read of 0x1000_0040 misses. With SPARSE_SYNCRAM_STATS_EN, hit_cnt and miss_cnt read 0 after reset.

Source files
------------

// File: rtl/sparse_syncram_if.sv
// Bus interface for sparse_syncram: request, write data, read response and
// occupancy status. The master drives requests, the slave (the RAM) answers.
// Build option: SPARSE_SYNCRAM_STATS_EN adds the hit_cnt/miss_cnt outputs.
interface sparse_syncram_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            cs;
  logic            we;
  logic            oe;
  logic            clr;
  logic [DW/8-1:0] be;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   din;
  logic [DW-1:0]   dout;
  logic            rd_valid;
  logic            rd_miss;
  logic            wr_drop;
  logic            full;
  logic [CW-1:0]   count;
`ifdef SPARSE_SYNCRAM_STATS_EN
  logic [15:0]     hit_cnt;
  logic [15:0]     miss_cnt;
`endif

  modport master (
    output cs, we, oe, clr, be, addr, din,
`ifdef SPARSE_SYNCRAM_STATS_EN
    input  hit_cnt, miss_cnt,
`endif
    input  dout, rd_valid, rd_miss, wr_drop, full, count
  );

  modport slave (
    input  cs, we, oe, clr, be, addr, din,
`ifdef SPARSE_SYNCRAM_STATS_EN
    output hit_cnt, miss_cnt,
`endif
    output dout, rd_valid, rd_miss, wr_drop, full, count
  );
endinterface

// File: rtl/sparse_syncram.sv
// Associative (sparse) synchronous RAM: up to DEPTH tag/data pairs looked up
// by full-address match. Byte-enabled writes, entry invalidation, full/miss
// reporting and a one-cycle registered read (read-before-write).
// Build option: SPARSE_SYNCRAM_STATS_EN adds saturating read hit/miss counters.
module sparse_syncram #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  sparse_syncram_if.slave   bus
);
  localparam int NB = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    tag_reg  [DEPTH];
  logic [DW-1:0]    data_reg [DEPTH];
  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             full_reg;
  logic [DW-1:0]    dout_reg;
  logic             rd_valid_reg, rd_miss_reg, wr_drop_reg;

  logic [DEPTH-1:0] hit_vec;
  logic             hit_any, has_free;
  logic [IW-1:0]    hit_idx, free_idx, wr_idx;
  logic [DW-1:0]    old_word, wr_word;
  logic             do_rd, do_wr, do_clr;
  logic             wr_hit, wr_alloc, wr_full, clr_hit;

  // clr takes precedence over we; everything is gated by chip select
  assign do_rd  = bus.cs & bus.oe;
  assign do_clr = bus.cs & bus.clr;
  assign do_wr  = bus.cs & bus.we & ~bus.clr;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign hit_vec[gi] = valid_reg[gi] && (tag_reg[gi] == bus.addr);
    end
  endgenerate

  assign hit_any = |hit_vec;

  // Encode the (at most one) matching entry and the lowest free slot
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    has_free = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_vec[i]) hit_idx = IW'(i);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        free_idx = IW'(i);
        has_free = 1'b1;
      end
    end
  end

  assign wr_hit   = do_wr & hit_any;
  assign wr_alloc = do_wr & ~hit_any & has_free;
  assign wr_full  = do_wr & ~hit_any & ~has_free;
  assign clr_hit  = do_clr & hit_any;
  assign wr_idx   = hit_any ? hit_idx : free_idx;
  assign old_word = data_reg[hit_idx];

  // Disabled bytes keep their value on a hit and start at zero on allocation
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bytes
      assign wr_word[gi*8 +: 8] = bus.be[gi] ? bus.din[gi*8 +: 8]
                                : (hit_any ? old_word[gi*8 +: 8] : 8'h00);
    end
  endgenerate

  // Next valid vector and occupancy; clr and allocation never coincide
  always_comb begin
    valid_next = valid_reg;
    count_next = count_reg;
    if (wr_alloc) begin
      valid_next[free_idx] = 1'b1;
      count_next           = count_reg + CW'(1);
    end
    if (clr_hit) begin
      valid_next[hit_idx] = 1'b0;
      count_next          = count_reg - CW'(1);
    end
  end

  // Tag/data storage; contents are don't-care until the valid bit is set
  always_ff @(posedge clk) begin
    if (wr_hit || wr_alloc) begin
      data_reg[wr_idx] <= wr_word;
      if (wr_alloc) tag_reg[wr_idx] <= bus.addr;
    end
  end

  // Valid bits, occupancy, read response and drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      dout_reg     <= '0;
      rd_valid_reg <= 1'b0;
      rd_miss_reg  <= 1'b0;
      wr_drop_reg  <= 1'b0;
    end else begin
      valid_reg    <= valid_next;
      count_reg    <= count_next;
      full_reg     <= (count_next == CW'(DEPTH));
      rd_valid_reg <= do_rd;
      rd_miss_reg  <= do_rd & ~hit_any;
      wr_drop_reg  <= wr_full;
      if (do_rd) dout_reg <= hit_any ? old_word : '0;
    end
  end

  assign bus.dout     = dout_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_miss  = rd_miss_reg;
  assign bus.wr_drop  = wr_drop_reg;
  assign bus.full     = full_reg;
  assign bus.count    = count_reg;

`ifdef SPARSE_SYNCRAM_STATS_EN
  logic [15:0] hit_cnt_reg, miss_cnt_reg;

  // Saturating read statistics, updated on the edge that raises rd_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (do_rd) begin
      if (hit_any && hit_cnt_reg != 16'hFFFF) hit_cnt_reg <= hit_cnt_reg + 16'd1;
      if (!hit_any && miss_cnt_reg != 16'hFFFF) miss_cnt_reg <= miss_cnt_reg + 16'd1;
    end
  end

  assign bus.hit_cnt  = hit_cnt_reg;
  assign bus.miss_cnt = miss_cnt_reg;
`endif
endmodule

// File: tb/tb_sparse_syncram.sv
// Directed, table-driven bench for sparse_syncram (DEPTH=4) plus hand-written
// asynchronous-reset sequence. SPARSE_SYNCRAM_STATS_EN also checks counters.
module tb_sparse_syncram;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sparse_syncram_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

  sparse_syncram #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        cs, we, oe, clr;
    logic [3:0]  be;
    logic [31:0] addr, din;
    logic        e_rv, e_rm, e_wd, e_full;
    logic [2:0]  e_cnt;
    logic [31:0] e_dout;
  } vec_t;

  vec_t vecs [30];
  int errors = 0;
  int checks = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cs, we, oe, clr, input logic [3:0] be,
                       input logic [31:0] addr, din);
    bus.cs = cs; bus.we = we; bus.oe = oe; bus.clr = clr;
    bus.be = be; bus.addr = addr; bus.din = din;
  endtask

  initial begin
    //                cs we oe clr be     addr           din            rv rm wd fu cnt  dout
    vecs[0]  = '{1, 1, 0, 0, 4'hF, 32'h1000_0040, 32'hDEAD_BEEF, 0, 0, 0, 0, 3'd1, 32'h0};
    vecs[1]  = '{1, 0, 1, 0, 4'h0, 32'h1000_0040, 32'h0,         1, 0, 0, 0, 3'd1, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 0, 1, 0, 4'h0, 32'h0000_0004, 32'h0,         1, 1, 0, 0, 3'd1, 32'h0};
    vecs[3]  = '{1, 1, 0, 0, 4'h3, 32'h1000_0040, 32'h1234_5678, 0, 0, 0, 0, 3'd1, 32'h0};
    vecs[4]  = '{1, 0, 1, 0, 4'h0, 32'h1000_0040, 32'h0,         1, 0, 0, 0, 3'd1, 32'hDEAD_5678};
    vecs[5]  = '{1, 1, 0, 0, 4'hF, 32'h20,        32'hAAAA_AAAA, 0, 0, 0, 0, 3'd2, 32'hDEAD_5678};
    vecs[6]  = '{1, 1, 1, 0, 4'hF, 32'h20,        32'h5555_5555, 1, 0, 0, 0, 3'd2, 32'hAAAA_AAAA};
    vecs[7]  = '{1, 0, 1, 0, 4'h0, 32'h20,        32'h0,         1, 0, 0, 0, 3'd2, 32'h5555_5555};
    vecs[8]  = '{1, 1, 0, 0, 4'h5, 32'h30,        32'h1122_3344, 0, 0, 0, 0, 3'd3, 32'h5555_5555};
    vecs[9]  = '{1, 0, 1, 0, 4'h0, 32'h30,        32'h0,         1, 0, 0, 0, 3'd3, 32'h0022_0044};
    vecs[10] = '{1, 1, 0, 0, 4'hF, 32'h40,        32'h99,        0, 0, 0, 1, 3'd4, 32'h0022_0044};
    vecs[11] = '{1, 1, 0, 0, 4'hF, 32'h50,        32'h77,        0, 0, 1, 1, 3'd4, 32'h0022_0044};
    vecs[12] = '{1, 0, 1, 0, 4'h0, 32'h50,        32'h0,         1, 1, 0, 1, 3'd4, 32'h0};
    vecs[13] = '{1, 0, 0, 1, 4'h0, 32'h30,        32'h0,         0, 0, 0, 0, 3'd3, 32'h0};
    vecs[14] = '{1, 1, 0, 0, 4'hF, 32'h50,        32'h77,        0, 0, 0, 1, 3'd4, 32'h0};
    vecs[15] = '{1, 0, 1, 0, 4'h0, 32'h50,        32'h0,         1, 0, 0, 1, 3'd4, 32'h77};
    vecs[16] = '{1, 0, 0, 1, 4'h0, 32'h99,        32'h0,         0, 0, 0, 1, 3'd4, 32'h77};
    vecs[17] = '{1, 0, 1, 1, 4'h0, 32'h20,        32'h0,         1, 0, 0, 0, 3'd3, 32'h5555_5555};
    vecs[18] = '{1, 1, 0, 0, 4'hF, 32'h60,        32'h66,        0, 0, 0, 1, 3'd4, 32'h5555_5555};
    vecs[19] = '{1, 1, 0, 1, 4'hF, 32'h40,        32'hFF,        0, 0, 0, 0, 3'd3, 32'h5555_5555};
    vecs[20] = '{1, 0, 1, 0, 4'h0, 32'h40,        32'h0,         1, 1, 0, 0, 3'd3, 32'h0};
    vecs[21] = '{0, 1, 0, 0, 4'hF, 32'h70,        32'h1,         0, 0, 0, 0, 3'd3, 32'h0};
    vecs[22] = '{1, 0, 1, 0, 4'h0, 32'h70,        32'h0,         1, 1, 0, 0, 3'd3, 32'h0};
    vecs[23] = '{1, 1, 1, 0, 4'hF, 32'h80,        32'h12,        1, 1, 0, 1, 3'd4, 32'h0};
    vecs[24] = '{1, 0, 1, 0, 4'h0, 32'h80,        32'h0,         1, 0, 0, 1, 3'd4, 32'h12};
    vecs[25] = '{1, 1, 0, 0, 4'h0, 32'h80,        32'hFFFF_FFFF, 0, 0, 0, 1, 3'd4, 32'h12};
    vecs[26] = '{1, 0, 1, 0, 4'h0, 32'h80,        32'h0,         1, 0, 0, 1, 3'd4, 32'h12};
    vecs[27] = '{0, 0, 1, 0, 4'h0, 32'h80,        32'h0,         0, 0, 0, 1, 3'd4, 32'h12};
    vecs[28] = '{1, 1, 0, 0, 4'h8, 32'h60,        32'hAB00_0000, 0, 0, 0, 1, 3'd4, 32'h12};
    vecs[29] = '{1, 0, 1, 0, 4'h0, 32'h60,        32'h0,         1, 0, 0, 1, 3'd4, 32'hAB00_0066};

    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    #12;
    chk("reset rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("reset rd_miss",  {31'd0, bus.rd_miss},  32'd0);
    chk("reset wr_drop",  {31'd0, bus.wr_drop},  32'd0);
    chk("reset full",     {31'd0, bus.full},     32'd0);
    chk("reset count",    {29'd0, bus.count},    32'd0);
    chk("reset dout",     bus.dout,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      drive(vecs[i].cs, vecs[i].we, vecs[i].oe, vecs[i].clr, vecs[i].be, vecs[i].addr, vecs[i].din);
      @(posedge clk);
      #1;
      $display("vec %0d cs=%b we=%b oe=%b clr=%b be=%h addr=%h din=%h -> rv=%b rm=%b wd=%b full=%b cnt=%0d dout=%h",
               i, vecs[i].cs, vecs[i].we, vecs[i].oe, vecs[i].clr, vecs[i].be, vecs[i].addr,
               vecs[i].din, bus.rd_valid, bus.rd_miss, bus.wr_drop, bus.full, bus.count, bus.dout);
      chk($sformatf("v%0d rd_valid", i), {31'd0, bus.rd_valid}, {31'd0, vecs[i].e_rv});
      chk($sformatf("v%0d rd_miss", i),  {31'd0, bus.rd_miss},  {31'd0, vecs[i].e_rm});
      chk($sformatf("v%0d wr_drop", i),  {31'd0, bus.wr_drop},  {31'd0, vecs[i].e_wd});
      chk($sformatf("v%0d full", i),     {31'd0, bus.full},     {31'd0, vecs[i].e_full});
      chk($sformatf("v%0d count", i),    {29'd0, bus.count},    {29'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d dout", i),     bus.dout,              vecs[i].e_dout);
      if (vecs[i].e_rv && !vecs[i].e_rm) exp_hits++;
      if (vecs[i].e_rv && vecs[i].e_rm) exp_misses++;
`ifdef SPARSE_SYNCRAM_STATS_EN
      chk($sformatf("v%0d hit_cnt", i),  {16'd0, bus.hit_cnt},  exp_hits);
      chk($sformatf("v%0d miss_cnt", i), {16'd0, bus.miss_cnt}, exp_misses);
`endif
      @(negedge clk);
    end

    // Read request in flight, then asynchronous reset between clock edges
    drive(1, 0, 1, 0, 4'h0, 32'h1000_0040, 32'h0);
    @(posedge clk);
    #1;
    $display("rst seq read addr=10000040 -> rv=%b dout=%h", bus.rd_valid, bus.dout);
    chk("pre-rst rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("pre-rst dout",     bus.dout,              32'hDEAD_5678);
    #1;
    rst_n = 1'b0;
    #1;
    $display("async reset -> rv=%b dout=%h cnt=%0d full=%b", bus.rd_valid, bus.dout, bus.count, bus.full);
    chk("async rst rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("async rst dout",     bus.dout,              32'd0);
    chk("async rst count",    {29'd0, bus.count},    32'd0);
    chk("async rst full",     {31'd0, bus.full},     32'd0);
`ifdef SPARSE_SYNCRAM_STATS_EN
    chk("async rst hit_cnt",  {16'd0, bus.hit_cnt},  32'd0);
    chk("async rst miss_cnt", {16'd0, bus.miss_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 1, 0, 4'h0, 32'h1000_0040, 32'h0);
    @(posedge clk);
    #1;
    $display("post-rst read addr=10000040 -> rv=%b rm=%b dout=%h", bus.rd_valid, bus.rd_miss, bus.dout);
    chk("post-rst rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("post-rst rd_miss",  {31'd0, bus.rd_miss},  32'd1);
    chk("post-rst dout",     bus.dout,              32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("idle rd_valid", {31'd0, bus.rd_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
